// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the 16-bit processor.
// Owns the program counter and drives the instruction memory address.
// Absorbs the memory's one-cycle registered read latency and holds each
// fetched word in the instruction register (ir). The word is offered to the
// control unit over an ir_valid / ir_ready handshake.
// A pc_load redirect squashes any fetch or handshake in flight.
// Optional build macro FETCH_PC_TRACE_EN adds the ir_pc output, which is the
// address that the current ir was fetched from.
module instr_fetch #(
    parameter int ADDR_W   = 32'd5,
    parameter int DATA_W   = 32'd16,
    parameter int RESET_PC = 32'd0
) (
    input  logic              MClock,
    input  logic              Resetn,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] pc
`ifdef FETCH_PC_TRACE_EN
    ,
    output logic [ADDR_W-1:0] ir_pc
`endif
);

    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_VALID   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] ir_r;
    logic              ir_valid_r;
    logic              capture_en_s;
    logic              accept_s;

    // FSM state register
    always_ff @(posedge MClock or negedge Resetn) begin
        if (!Resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; a redirect overrides every state
    always_comb begin
        state_nx_s = state_r;
        if (pc_load) begin
            if (run) begin
                state_nx_s = ST_FETCH;
            end else begin
                state_nx_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run) begin
                        state_nx_s = ST_FETCH;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_nx_s = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state_nx_s = ST_VALID;
                end
                ST_VALID: begin
                    if (ir_ready) begin
                        if (run) begin
                            state_nx_s = ST_FETCH;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
                    end else begin
                        state_nx_s = ST_VALID;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM output decode: capture strobe and accepted-handshake strobe
    always_comb begin
        capture_en_s = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            ST_CAPTURE: begin
                capture_en_s = ~pc_load;
            end
            ST_VALID: begin
                accept_s = ir_ready & ~pc_load;
            end
            default: begin
                capture_en_s = 1'b0;
                accept_s     = 1'b0;
            end
        endcase
    end

    // Program counter: redirect wins, otherwise advance once per captured word
    always_ff @(posedge MClock or negedge Resetn) begin
        if (!Resetn) begin
            pc_r <= RESET_PC_V;
        end else if (pc_load) begin
            pc_r <= pc_in;
        end else if (capture_en_s) begin
            pc_r <= pc_r + PC_ONE;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Instruction register: loads memory data only on a non-squashed capture
    always_ff @(posedge MClock or negedge Resetn) begin
        if (!Resetn) begin
            ir_r <= {DATA_W{1'b0}};
        end else if (capture_en_s) begin
            ir_r <= mem_data;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Valid flag: set by a capture, cleared by an accepted beat or a redirect
    always_ff @(posedge MClock or negedge Resetn) begin
        if (!Resetn) begin
            ir_valid_r <= 1'b0;
        end else if (pc_load) begin
            ir_valid_r <= 1'b0;
        end else if (capture_en_s) begin
            ir_valid_r <= 1'b1;
        end else if (accept_s) begin
            ir_valid_r <= 1'b0;
        end else begin
            ir_valid_r <= ir_valid_r;
        end
    end

`ifdef FETCH_PC_TRACE_EN
    logic [ADDR_W-1:0] ir_pc_r;

    // Fetch-address trace: remembers the pre-increment pc of the captured word
    always_ff @(posedge MClock or negedge Resetn) begin
        if (!Resetn) begin
            ir_pc_r <= RESET_PC_V;
        end else if (capture_en_s) begin
            ir_pc_r <= pc_r;
        end else begin
            ir_pc_r <= ir_pc_r;
        end
    end

    assign ir_pc = ir_pc_r;
`endif

    assign mem_addr = pc_r;
    assign pc       = pc_r;
    assign ir       = ir_r;
    assign ir_valid = ir_valid_r;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the 16-bit processor, directly upstream of the instruction memory.
- Owns the program counter, drives the 5-bit memory address and absorbs the memory's one-cycle registered read latency.
- Latches each fetched word into the instruction register (IR) and presents it to the control unit over a valid/ready handshake.
- Supports a PC redirect (jump/branch) from the control unit that squashes any in-flight fetch.

Parameters:
- ADDR_W, 5, PC / memory address width (32-word memory)
- DATA_W, 16, instruction width
- RESET_PC, 0, PC value loaded on reset

Ports:
- MClock  in  1  system clock; all state updates on rising edge
- Resetn  in  1  asynchronous active-low reset
- run  in  1  1 = fetching enabled; 0 = stop after the current instruction is consumed
- mem_addr  out  ADDR_W  address to instruction memory; always equals pc
- mem_data  in  DATA_W  registered read data from memory (valid the cycle after address sampled)
- ir  out  DATA_W  instruction register
- ir_valid  out  1  ir holds an unconsumed instruction
- ir_ready  in  1  control unit accepts ir this cycle
- pc_load  in  1  redirect PC
- pc_in  in  ADDR_W  redirect target
- pc  out  ADDR_W  current program counter (address of next fetch)

Behaviour:
- Reset (Resetn=0, asynchronous, any state, mid-fetch included): pc=RESET_PC, ir=0, ir_valid=0, state=IDLE. In-flight memory data is ignored after release.
- mem_addr is combinationally equal to pc at all times.
- States IDLE, FETCH, CAPTURE, VALID; one-hot or binary, implementer's choice.
- IDLE: ir_valid=0. Next state is FETCH if run=1, else IDLE.
- FETCH: mem_addr=pc. The memory samples the address on this edge. Next state is CAPTURE unconditionally (run ignored).
- CAPTURE: mem_data now valid. On the edge: ir<=mem_data; pc<=pc+1 modulo 2^ADDR_W (31 wraps to 0); ir_valid<=1; next state VALID.
- VALID: ir_valid=1, ir stable. Handshake fires on an edge where ir_valid&&ir_ready.
  - On handshake: ir_valid<=0; next state FETCH if run=1, else IDLE.
  - Without ready: hold in VALID with ir and pc unchanged.
- Throughput: 3 cycles per instruction when ir_ready is held high.
- Fetch latency: 2 cycles from entering FETCH to ir_valid=1.
- pc_load (any state, highest priority below reset): pc<=pc_in; ir_valid<=0; next state FETCH if run=1, else IDLE.
  - In CAPTURE: mem_data is discarded, ir unchanged, pc not incremented.
  - In VALID with ir_ready=1: the handshake is squashed and the instruction is not considered accepted.
- ir retains its last value while ir_valid=0. The consumer must only sample ir when ir_valid=1.
- run=0 never aborts a fetch already past IDLE; it only prevents the next one from starting.

Optional Feature:
- Macro: FETCH_PC_TRACE_EN
- Defined: adds output ir_pc [ADDR_W-1:0], the address from which the current ir was fetched.
  - Loaded with pc in CAPTURE, i.e. the pre-increment value.
  - Reset value RESET_PC.
  - Holds while ir_valid=0.
  - Used by the control unit for PC-relative branches and by debug.
- Not defined: port absent, no extra flops. All other behaviour identical.

Test Plan:
- Reset then run=1, ir_ready=1, Mem[0]=0x0040, Mem[1]=0x0000: ir_valid rises 2 cycles after FETCH with ir=0x0040, pc=1; next instruction ir=0x0000 with pc=2, 3 cycles later.
- ir_ready=0 for 5 cycles in VALID: ir, pc and ir_valid held constant; the handshake on the 6th cycle returns the FSM to FETCH.
- pc=31, fetch completes: pc wraps to 0 and the next fetch reads Mem[0].
- pc_load=1, pc_in=5 asserted during CAPTURE of address 2: ir not updated, ir_valid stays 0, next ir is Mem[5], pc=6 afterwards.
- pc_load and ir_ready both high in VALID: ir_valid drops, pc=pc_in, and the consumer sees no accepted beat.
- Resetn pulsed low during CAPTURE: outputs immediately return to pc=0, ir=0, ir_valid=0 (without waiting for a clock edge); with FETCH_PC_TRACE_EN, ir_pc tracks the fetch address (ir_pc=3 for a word fetched from address 3).
